// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter
//   Store-and-forward receive buffer behind the MAC receive stream. Every
//   incoming byte is accepted. Errored frames, runts (<6 bytes), overflowing
//   frames and frames not addressed to this station are discarded. A frame is
//   only exposed on the output stream once its last byte has been stored.
//
// Ports
//   clk, rst_n           single clock, asynchronous active-low reset
//   s_axis_t*            MAC byte stream in (no tready; tuser qualifies tlast)
//   m_axis_t*            filtered byte stream out, backpressured by tready
//   cfg_local_mac        station address, [47:40] is the first byte on the wire
//   cfg_promisc          1: accept any destination address
//   stat_*               one-cycle pulses, exactly one per received frame
//
// Output handshake: a byte moves when m_axis_tvalid & m_axis_tready are both
// high at a rising edge; while tvalid is high and tready is low, tdata/tlast
// hold and tvalid stays high.
module eth_rx_frame_filter #(
    parameter int DEPTH        = 4096,
    parameter bit ACCEPT_MCAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic [47:0] cfg_local_mac,
    input  logic        cfg_promisc,
    output logic        stat_frame_ok,
    output logic        stat_drop_bad,
    output logic        stat_drop_addr,
    output logic        stat_drop_ovf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_DEPTH = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DROP} wr_state_e;

    wr_state_e       state_q;
    logic [2:0]      hdr_cnt_q;
    logic            uc_q, bc_q, mc_q;
    logic            drop_ovf_q;
    logic [ADDR_W:0] wr_ptr_q, wr_commit_q, rd_ptr_q;
    logic [8:0]      mem_q [DEPTH];
    logic            stat_ok_q, stat_bad_q, stat_addr_q, stat_ovf_q;
    logic [7:0]      m_tdata_q;
    logic            m_tvalid_q, m_tlast_q;

    // Buffer occupancy; wr_ptr and rd_ptr carry one extra wrap bit.
    logic [ADDR_W:0] fill;
    logic            full, readable, load;
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign full     = (fill == PTR_DEPTH);
    assign readable = (rd_ptr_q != wr_commit_q);
    assign load     = readable && (!m_tvalid_q || m_axis_tready);

    // Destination address tracking: the running match flags restart at byte 0.
    logic [7:0] mac_byte;
    logic       uc_now, bc_now, mc_now, addr_ok, hdr_last, runt, mem_we;

    always_comb begin
        mac_byte = cfg_local_mac[7:0];
        case ((state_q == S_IDLE) ? 3'd0 : hdr_cnt_q)
            3'd0:    mac_byte = cfg_local_mac[47:40];
            3'd1:    mac_byte = cfg_local_mac[39:32];
            3'd2:    mac_byte = cfg_local_mac[31:24];
            3'd3:    mac_byte = cfg_local_mac[23:16];
            3'd4:    mac_byte = cfg_local_mac[15:8];
            default: mac_byte = cfg_local_mac[7:0];
        endcase
    end

    assign uc_now   = ((state_q == S_IDLE) || uc_q) && (s_axis_tdata == mac_byte);
    assign bc_now   = ((state_q == S_IDLE) || bc_q) && (s_axis_tdata == 8'hFF);
    assign mc_now   = (state_q == S_IDLE) ? s_axis_tdata[0] : mc_q;
    assign addr_ok  = cfg_promisc || uc_now || bc_now || (ACCEPT_MCAST && mc_now);
    assign hdr_last = (state_q == S_HDR) && (hdr_cnt_q == 3'd5);
    assign runt     = (state_q == S_IDLE) || ((state_q == S_HDR) && !hdr_last);
    assign mem_we   = s_axis_tvalid && (state_q != S_DROP) && !full;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Write FSM. Any discard rewinds wr_ptr to the last committed frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hdr_cnt_q   <= 3'd0;
            uc_q        <= 1'b0;
            bc_q        <= 1'b0;
            mc_q        <= 1'b0;
            drop_ovf_q  <= 1'b0;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            stat_ok_q   <= 1'b0;
            stat_bad_q  <= 1'b0;
            stat_addr_q <= 1'b0;
            stat_ovf_q  <= 1'b0;
        end else begin
            stat_ok_q   <= 1'b0;
            stat_bad_q  <= 1'b0;
            stat_addr_q <= 1'b0;
            stat_ovf_q  <= 1'b0;
            if (s_axis_tvalid) begin
                if (state_q == S_DROP) begin
                    if (s_axis_tlast) begin
                        state_q <= S_IDLE;
                        if (drop_ovf_q) stat_ovf_q <= 1'b1;
                        else            stat_addr_q <= 1'b1;
                    end
                end else if (full) begin
                    wr_ptr_q <= wr_commit_q;
                    if (s_axis_tlast) begin
                        stat_ovf_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        drop_ovf_q <= 1'b1;
                        state_q    <= S_DROP;
                    end
                end else begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    uc_q     <= uc_now;
                    bc_q     <= bc_now;
                    mc_q     <= mc_now;
                    if (s_axis_tlast) begin
                        state_q <= S_IDLE;
                        if (hdr_last && !addr_ok) begin
                            wr_ptr_q    <= wr_commit_q;
                            stat_addr_q <= 1'b1;
                        end else if (runt || s_axis_tuser) begin
                            wr_ptr_q   <= wr_commit_q;
                            stat_bad_q <= 1'b1;
                        end else begin
                            wr_commit_q <= wr_ptr_q + PTR_ONE;
                            stat_ok_q   <= 1'b1;
                        end
                    end else if (state_q == S_IDLE) begin
                        hdr_cnt_q <= 3'd1;
                        state_q   <= S_HDR;
                    end else if (hdr_last) begin
                        if (addr_ok) begin
                            state_q <= S_BODY;
                        end else begin
                            wr_ptr_q   <= wr_commit_q;
                            drop_ovf_q <= 1'b0;
                            state_q    <= S_DROP;
                        end
                    end else if (state_q == S_HDR) begin
                        hdr_cnt_q <= hdr_cnt_q + 3'd1;
                    end
                end
            end
        end
    end

    // Output register stage; refills in the same cycle it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 8'd0;
            m_tlast_q  <= 1'b0;
        end else if (load) begin
            {m_tlast_q, m_tdata_q} <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            m_tvalid_q <= 1'b1;
            rd_ptr_q   <= rd_ptr_q + PTR_ONE;
        end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign m_axis_tdata   = m_tdata_q;
    assign m_axis_tvalid  = m_tvalid_q;
    assign m_axis_tlast   = m_tlast_q;
    assign stat_frame_ok  = stat_ok_q;
    assign stat_drop_bad  = stat_bad_q;
    assign stat_drop_addr = stat_addr_q;
    assign stat_drop_ovf  = stat_ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Directed bench for eth_rx_frame_filter. Two instances share the receive
// stream: dut_a (DEPTH 4096) for the general cases, dut_b (DEPTH 64) for the
// overflow case.
module tb_eth_rx_frame_filter;

    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tuser;
    logic [47:0] cfg_mac;
    logic        cfg_promisc;

    logic [7:0] a_tdata, b_tdata;
    logic       a_tvalid, a_tlast, b_tvalid, b_tlast;
    logic       a_tready = 1'b0;
    logic       b_tready;
    logic       a_ok, a_bad, a_addr, a_ovf, b_ok, b_bad, b_addr, b_ovf;

    logic a_hold = 1'b1;
    logic a_rand = 1'b0;

    eth_rx_frame_filter #(.DEPTH(4096), .ACCEPT_MCAST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(a_tready), .m_axis_tlast(a_tlast),
        .cfg_local_mac(cfg_mac), .cfg_promisc(cfg_promisc),
        .stat_frame_ok(a_ok), .stat_drop_bad(a_bad),
        .stat_drop_addr(a_addr), .stat_drop_ovf(a_ovf)
    );

    eth_rx_frame_filter #(.DEPTH(64), .ACCEPT_MCAST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(b_tready), .m_axis_tlast(b_tlast),
        .cfg_local_mac(cfg_mac), .cfg_promisc(cfg_promisc),
        .stat_frame_ok(b_ok), .stat_drop_bad(b_bad),
        .stat_drop_addr(b_addr), .stat_drop_ovf(b_ovf)
    );

    // tready for dut_a: fixed level or random (75% ready), driven mid-cycle
    always @(posedge clk) begin
        #2;
        a_tready = a_rand ? ($urandom_range(0, 3) != 0) : a_hold;
    end

    // monitor: transfers and stat pulses sampled on the falling edge
    logic [8:0] a_got_q[$], b_got_q[$];
    int a_n_ok, a_n_bad, a_n_addr, a_n_ovf, b_n_ok, b_n_bad, b_n_addr, b_n_ovf;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_tvalid && a_tready) a_got_q.push_back({a_tlast, a_tdata});
            if (b_tvalid && b_tready) b_got_q.push_back({b_tlast, b_tdata});
            if (a_ok)   a_n_ok++;
            if (a_bad)  a_n_bad++;
            if (a_addr) a_n_addr++;
            if (a_ovf)  a_n_ovf++;
            if (b_ok)   b_n_ok++;
            if (b_bad)  b_n_bad++;
            if (b_addr) b_n_addr++;
            if (b_ovf)  b_n_ovf++;
        end
    end

    // scoreboard
    logic [8:0] a_exp_q[$], b_exp_q[$];
    int a_base, b_base;
    int a_ok0, a_bad0, a_addr0, a_ovf0, b_ok0, b_bad0, b_addr0, b_ovf0;
    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic snap();
        a_base = a_got_q.size();
        b_base = b_got_q.size();
        a_exp_q.delete();
        b_exp_q.delete();
        a_ok0 = a_n_ok; a_bad0 = a_n_bad; a_addr0 = a_n_addr; a_ovf0 = a_n_ovf;
        b_ok0 = b_n_ok; b_bad0 = b_n_bad; b_addr0 = b_n_addr; b_ovf0 = b_n_ovf;
    endtask

    task automatic check_stream_a(input string tag);
        check({tag, "_len"}, a_got_q.size() - a_base, a_exp_q.size());
        for (int i = 0; i < a_exp_q.size(); i++) begin
            if (a_base + i < a_got_q.size()) check({tag, "_byte"}, a_got_q[a_base + i], a_exp_q[i]);
        end
    endtask

    task automatic check_stream_b(input string tag);
        check({tag, "_len"}, b_got_q.size() - b_base, b_exp_q.size());
        for (int i = 0; i < b_exp_q.size(); i++) begin
            if (b_base + i < b_got_q.size()) check({tag, "_byte"}, b_got_q[b_base + i], b_exp_q[i]);
        end
    endtask

    task automatic check_stats_a(input string tag, input int ok, input int bad, input int addr, input int ovf);
        check({tag, "_ok"},   a_n_ok - a_ok0, ok);
        check({tag, "_bad"},  a_n_bad - a_bad0, bad);
        check({tag, "_addr"}, a_n_addr - a_addr0, addr);
        check({tag, "_ovf"},  a_n_ovf - a_ovf0, ovf);
    endtask

    task automatic check_stats_b(input string tag, input int ok, input int bad, input int addr, input int ovf);
        check({tag, "_ok"},   b_n_ok - b_ok0, ok);
        check({tag, "_bad"},  b_n_bad - b_bad0, bad);
        check({tag, "_addr"}, b_n_addr - b_addr0, addr);
        check({tag, "_ovf"},  b_n_ovf - b_ovf0, ovf);
    endtask

    // driver
    function automatic logic [7:0] fbyte(input logic [47:0] dst, input int i, input logic [7:0] seed);
        if (i < 6) return dst[8*(5-i) +: 8];
        return seed + 8'(i);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; leaves the same phase.
    task automatic send_frame(input logic [47:0] dst, input int len, input logic bad,
                              input logic [7:0] seed, input logic exp_a, input logic exp_b);
        for (int i = 0; i < len; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = fbyte(dst, i, seed);
            s_tlast  = (i == len - 1);
            s_tuser  = bad && (i == len - 1);
            if (exp_a) a_exp_q.push_back({s_tlast, s_tdata});
            if (exp_b) b_exp_q.push_back({s_tlast, s_tdata});
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        s_tdata  = 8'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        cfg_mac = MAC; cfg_promisc = 1'b0;
        b_tready = 1'b1;
        wait_cycles(3);

        // reset state
        check("rst_a_tvalid", a_tvalid, 0);
        check("rst_a_tdata", a_tdata, 0);
        check("rst_a_tlast", a_tlast, 0);
        check("rst_a_stats", {a_ok, a_bad, a_addr, a_ovf}, 0);
        check("rst_b_tvalid", b_tvalid, 0);
        check("rst_b_stats", {b_ok, b_bad, b_addr, b_ovf}, 0);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1) 64-byte good frame to our address
        snap();
        send_frame(MAC, 64, 1'b0, 8'h10, 1'b1, 1'b0);
        wait_cycles(100);
        check_stream_a("t1");
        check_stats_a("t1", 1, 0, 0, 0);

        // 2) errored frame dropped, following good frame intact
        snap();
        send_frame(MAC, 64, 1'b1, 8'h20, 1'b0, 1'b0);
        wait_cycles(80);
        check("t2_bad_len", a_got_q.size() - a_base, 0);
        check_stats_a("t2_bad", 0, 1, 0, 0);
        snap();
        send_frame(MAC, 64, 1'b0, 8'h30, 1'b1, 1'b0);
        wait_cycles(100);
        check_stream_a("t2_good");
        check_stats_a("t2_good", 1, 0, 0, 0);

        // 3) address filtering
        snap();
        send_frame(OTHER, 20, 1'b0, 8'h40, 1'b0, 1'b0);
        wait_cycles(40);
        check("t3_mismatch_len", a_got_q.size() - a_base, 0);
        check_stats_a("t3_mismatch", 0, 0, 1, 0);
        snap();
        cfg_promisc = 1'b1;
        send_frame(OTHER, 20, 1'b0, 8'h50, 1'b1, 1'b0);
        wait_cycles(40);
        cfg_promisc = 1'b0;
        check_stream_a("t3_promisc");
        check_stats_a("t3_promisc", 1, 0, 0, 0);
        snap();
        send_frame(BCAST, 16, 1'b0, 8'h60, 1'b1, 1'b0);
        send_frame(MCAST, 16, 1'b0, 8'h70, 1'b1, 1'b0);
        send_frame(MAC, 6, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_cycles(80);
        check_stream_a("t3_bc_mc_min");
        check_stats_a("t3_bc_mc_min", 3, 0, 0, 0);

        // 5) runts, then back-to-back frames with random tready
        snap();
        send_frame(MAC, 3, 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(MAC, 5, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_cycles(20);
        check("t5_runt_len", a_got_q.size() - a_base, 0);
        check_stats_a("t5_runt", 0, 2, 0, 0);
        snap();
        a_rand = 1'b1;
        send_frame(MAC, 60, 1'b0, 8'h80, 1'b1, 1'b0);
        send_frame(MAC, 60, 1'b0, 8'h90, 1'b1, 1'b0);
        send_frame(MAC, 60, 1'b0, 8'hA0, 1'b1, 1'b0);
        wait_cycles(400);
        a_rand = 1'b0;
        wait_cycles(2);
        check_stream_a("t5_b2b");
        check_stats_a("t5_b2b", 3, 0, 0, 0);

        // 4) overflow on the 64-byte instance
        rst_n = 1'b0;
        b_tready = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        snap();
        send_frame(MAC, 40, 1'b0, 8'hB0, 1'b0, 1'b1);
        send_frame(MAC, 40, 1'b0, 8'hC0, 1'b0, 1'b0);
        wait_cycles(5);
        check("t4_stall_len", b_got_q.size() - b_base, 0);
        check("t4_stall_valid", b_tvalid, 1);
        check("t4_stall_data", b_tdata, MAC[47:40]);
        check("t4_stall_last", b_tlast, 0);
        check_stats_b("t4", 1, 0, 0, 1);
        b_tready = 1'b1;
        wait_cycles(80);
        check_stream_b("t4_drain");

        // 6) reset while the output holds a byte
        a_hold = 1'b0;
        wait_cycles(2);
        send_frame(MAC, 20, 1'b0, 8'hD0, 1'b0, 1'b0);
        wait_cycles(5);
        check("t6_pre_valid", a_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", a_tvalid, 0);
        check("t6_rst_data", a_tdata, 0);
        check("t6_rst_last", a_tlast, 0);
        check("t6_rst_stats", {a_ok, a_bad, a_addr, a_ovf}, 0);
        wait_cycles(2);
        rst_n = 1'b1;
        a_hold = 1'b1;
        wait_cycles(2);
        snap();
        send_frame(MAC, 30, 1'b0, 8'hE0, 1'b1, 1'b0);
        wait_cycles(80);
        check_stream_a("t6_post");
        check_stats_a("t6_post", 1, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
